// File: rtl/hazard_tnew_tracker_pkg.sv
// Shared constants and helpers for the Tnew/Tuse hazard tracker.
package hazard_tnew_tracker_pkg;

  localparam logic [2:0] NOTUSE = 3'd7;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [1:0] TNEW_ZERO = 2'd0;  // lui, jal
  localparam logic [1:0] TNEW_ALU  = 2'd1;  // ALU ops, mfhi, mflo
  localparam logic [1:0] TNEW_LOAD = 2'd2;  // loads

  typedef struct packed {
    logic       valid;
    logic [4:0] a3;
    logic [1:0] tnew;
  } slot_t;

  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.valid && (s.a3 == r) && (r != 5'd0);
  endfunction

  // The nearest matching producer decides; an older match is shadowed by it.
  function automatic logic op_blocks(input slot_t e, input slot_t m, input logic [4:0] r,
                                     input logic [2:0] tuse);
    if (tuse == NOTUSE) return 1'b0;
    if (slot_hit(e, r)) return {1'b0, e.tnew} > tuse;
    return slot_hit(m, r) && ({1'b0, m.tnew} > tuse);
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t e, input slot_t m, input slot_t w,
                                         input logic [4:0] r);
    if (slot_hit(e, r)) return FWD_E;
    if (slot_hit(m, r)) return FWD_M;
    if (slot_hit(w, r)) return FWD_W;
    return FWD_GRF;
  endfunction

endpackage

// File: rtl/hazard_tnew_tracker_if.sv
// D-stage demand inputs and hazard outputs of the tracker.
interface hazard_tnew_tracker_if;
  logic [2:0] d_tuse_rs;
  logic [2:0] d_tuse_rt;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] d_a3;
  logic [1:0] d_tnew;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       md_busy;

  modport master (
    output d_tuse_rs, d_tuse_rt, d_rs, d_rt, d_a3, d_tnew, d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs, fwd_rt, md_busy
  );

  modport slave (
    input  d_tuse_rs, d_tuse_rt, d_rs, d_rt, d_a3, d_tnew, d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs, fwd_rt, md_busy
  );
endinterface

// File: rtl/hazard_md_counter.sv
// HI/LO multiply/divide busy counter: loads on an md start in E, then counts down.
module hazard_md_counter #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  logic [4:0] count_q, count_d;

  // Load on start, otherwise decrement toward zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = div_i ? 5'(DivCycles) : 5'(MultCycles);
    end else if (count_q != 5'd0) begin
      count_d = count_q - 5'd1;
    end
  end

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= 5'd0;
    else         count_q <= count_d;
  end

  assign busy_o = (count_q != 5'd0);

endmodule

// File: rtl/hazard_tnew_tracker.sv
// Producer-side hazard unit: E/M/W Tnew tracking, D stall and forwarding selects.
// Optional HI/LO busy tracking is built when MD_HAZARD_EN is defined.
module hazard_tnew_tracker
  import hazard_tnew_tracker_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic                  clk,
  input logic                  reset,
  hazard_tnew_tracker_if.slave hz
);

  slot_t      e_q, e_d, m_q, m_d, w_slot;
  logic       w_valid_q;
  logic [4:0] w_a3_q;
  logic       rs_stall, rt_stall, md_stall, stall;

  // W results are always ready, so only valid and a3 are kept.
  assign w_slot = '{valid: w_valid_q, a3: w_a3_q, tnew: TNEW_ZERO};

  // Next slot contents: E takes D or a bubble, M ages E by one cycle.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.valid = 1'b1;
      e_d.a3    = hz.d_a3;
      e_d.tnew  = hz.d_tnew;
    end
    m_d       = e_q;
    m_d.tnew  = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
  end

  // Pipeline slot registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_valid_q <= 1'b0;
      w_a3_q    <= 5'd0;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      w_valid_q <= m_q.valid;
      w_a3_q    <= m_q.a3;
    end
  end

`ifdef MD_HAZARD_EN
  logic e_md_start_q, e_md_div_q, md_busy;

  // Track whether E holds a mult/div start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
    end else begin
      e_md_start_q <= !stall && hz.d_md_start;
      e_md_div_q   <= !stall && hz.d_md_div;
    end
  end

  hazard_md_counter #(
    .MultCycles(MULT_CYCLES),
    .DivCycles (DIV_CYCLES)
  ) u_md_counter (
    .clk_i (clk),
    .rst_ni(reset),
    .load_i(e_md_start_q),
    .div_i (e_md_div_q),
    .busy_o(md_busy)
  );

  assign md_stall = hz.d_md_use && (e_md_start_q || md_busy);
`else
  logic md_busy;
  logic unused_md;

  assign unused_md = ^{hz.d_md_start, hz.d_md_div, hz.d_md_use,
                       5'(MULT_CYCLES), 5'(DIV_CYCLES)};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  // Stall and forwarding decisions from slot state and D demand.
  always_comb begin
    rs_stall  = op_blocks(e_q, m_q, hz.d_rs, hz.d_tuse_rs);
    rt_stall  = op_blocks(e_q, m_q, hz.d_rt, hz.d_tuse_rt);
    stall     = rs_stall | rt_stall | md_stall;
    hz.stall  = stall;
    hz.fwd_rs = fwd_sel(e_q, m_q, w_slot, hz.d_rs);
    hz.fwd_rt = fwd_sel(e_q, m_q, w_slot, hz.d_rt);
    hz.md_busy = md_busy;
  end

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Directed self-checking bench for hazard_tnew_tracker (MD_HAZARD_EN optional).
module tb_hazard_tnew_tracker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  hazard_tnew_tracker_if hz ();

  hazard_tnew_tracker #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_d(input logic [2:0] tuse_rs, input logic [2:0] tuse_rt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                       input logic [1:0] tnew, input logic md_start, input logic md_div,
                       input logic md_use);
    hz.d_tuse_rs  = tuse_rs;
    hz.d_tuse_rt  = tuse_rt;
    hz.d_rs       = rs;
    hz.d_rt       = rt;
    hz.d_a3       = a3;
    hz.d_tnew     = tnew;
    hz.d_md_start = md_start;
    hz.d_md_div   = md_div;
    hz.d_md_use   = md_use;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) tick();
    settle();
    check("rst_stall", 8'(hz.stall), 8'd0);
    check("rst_fwd_rs", 8'(hz.fwd_rs), 8'd0);
    check("rst_fwd_rt", 8'(hz.fwd_rt), 8'd0);
    check("rst_md_busy", 8'(hz.md_busy), 8'd0);
    reset = 1'b1;

    // lw $1 then add $2,$1,$3: one load-use stall, then forward from M.
    set_d(3'd1, 3'd7, 5'd29, 5'd0, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    settle();
    check("lw_issue_stall", 8'(hz.stall), 8'd0);
    tick();
    set_d(3'd1, 3'd1, 5'd1, 5'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    settle();
    check("lu_stall", 8'(hz.stall), 8'd1);
    tick();
    settle();
    check("lu_release", 8'(hz.stall), 8'd0);
    check("lu_fwd_rs", 8'(hz.fwd_rs), 8'd2);
    check("lu_fwd_rt", 8'(hz.fwd_rt), 8'd0);
    tick();

    // lui $5 then beq $5,$0: forward from E, r0 never matches.
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("lui_issue_stall", 8'(hz.stall), 8'd0);
    tick();
    set_d(3'd0, 3'd0, 5'd5, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("lui_beq_stall", 8'(hz.stall), 8'd0);
    check("lui_beq_fwd_rs", 8'(hz.fwd_rs), 8'd1);
    check("lui_beq_fwd_rt", 8'(hz.fwd_rt), 8'd0);
    tick();

    // addu $4 then beq $4: one stall, then forward from M.
    set_d(3'd1, 3'd1, 5'd8, 5'd9, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    settle();
    check("addu_issue_stall", 8'(hz.stall), 8'd0);
    tick();
    set_d(3'd0, 3'd0, 5'd4, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("alu_beq_stall", 8'(hz.stall), 8'd1);
    tick();
    settle();
    check("alu_beq_release", 8'(hz.stall), 8'd0);
    check("alu_beq_fwd_rs", 8'(hz.fwd_rs), 8'd2);
    tick();

    // $7 written in both E and M: nearest (E) wins; Tuse 7 never stalls.
    set_d(3'd1, 3'd7, 5'd0, 5'd0, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("r7_lui_stall", 8'(hz.stall), 8'd0);
    tick();
    set_d(3'd0, 3'd7, 5'd7, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("r7_em_stall", 8'(hz.stall), 8'd0);
    check("r7_em_fwd_rs", 8'(hz.fwd_rs), 8'd1);
    set_d(3'd1, 3'd7, 5'd0, 5'd0, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(3'd7, 3'd7, 5'd7, 5'd7, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("notuse_stall", 8'(hz.stall), 8'd0);
    check("notuse_fwd_rs", 8'(hz.fwd_rs), 8'd1);
    check("notuse_fwd_rt", 8'(hz.fwd_rt), 8'd1);
    hz.d_tuse_rs = 3'd1;
    settle();
    check("lw7_use_stall", 8'(hz.stall), 8'd1);

    // Reset while stalled on the load clears all slots.
    reset = 1'b0;
    tick();
    settle();
    check("rst_mid_stall", 8'(hz.stall), 8'd0);
    check("rst_mid_fwd_rs", 8'(hz.fwd_rs), 8'd0);
    check("rst_mid_md_busy", 8'(hz.md_busy), 8'd0);
    reset = 1'b1;
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();

`ifdef MD_HAZARD_EN
    // div then mfhi: busy for 10 cycles, stall until counter drains.
    set_d(3'd1, 3'd1, 5'd8, 5'd9, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    settle();
    check("div_issue_stall", 8'(hz.stall), 8'd0);
    check("div_issue_busy", 8'(hz.md_busy), 8'd0);
    tick();
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
    settle();
    check("div_e_stall", 8'(hz.stall), 8'd1);
    check("div_e_busy", 8'(hz.md_busy), 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      check("div_busy", 8'(hz.md_busy), 8'd1);
      check("div_busy_stall", 8'(hz.stall), 8'd1);
    end
    tick();
    settle();
    check("div_done_busy", 8'(hz.md_busy), 8'd0);
    check("div_done_stall", 8'(hz.stall), 8'd0);
    tick();

    // mult then mfhi: busy for 5 cycles.
    set_d(3'd1, 3'd1, 5'd8, 5'd9, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    settle();
    check("mult_issue_stall", 8'(hz.stall), 8'd0);
    tick();
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      settle();
      check("mult_busy", 8'(hz.md_busy), 8'd1);
      check("mult_busy_stall", 8'(hz.stall), 8'd1);
    end
    tick();
    settle();
    check("mult_done_busy", 8'(hz.md_busy), 8'd0);
    check("mult_done_stall", 8'(hz.stall), 8'd0);
    tick();

    // Reset in the middle of a mult drops the busy count at once.
    set_d(3'd1, 3'd1, 5'd8, 5'd9, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    settle();
    check("mult_pre_rst_busy", 8'(hz.md_busy), 8'd1);
    reset = 1'b0;
    tick();
    settle();
    check("mult_rst_busy", 8'(hz.md_busy), 8'd0);
    check("mult_rst_stall", 8'(hz.stall), 8'd0);
    reset = 1'b1;
`else
    // Without the HI/LO unit md inputs are ignored.
    set_d(3'd1, 3'd1, 5'd8, 5'd9, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(3'd7, 3'd7, 5'd0, 5'd0, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
    settle();
    check("nomd_stall", 8'(hz.stall), 8'd0);
    check("nomd_busy", 8'(hz.md_busy), 8'd0);
    tick();
    settle();
    check("nomd_busy_later", 8'(hz.md_busy), 8'd0);
    check("nomd_stall_later", 8'(hz.stall), 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
